// File: rtl/div_radix2.sv
// div_radix2: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Holds the E-stage instruction via stall_o until HI (remainder) / LO
// (quotient) are ready; aborts on exception flush.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Operand magnitudes; |most-negative| is naturally correct as unsigned
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    // One restoring iteration on the current partial remainder/quotient
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] iter_rem, iter_quo;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    assign accept = start_i & ~flush_i;
    assign a_neg  = signed_i & a_i[WIDTH-1];
    assign b_neg  = signed_i & b_i[WIDTH-1];
    assign abs_a  = a_neg ? (WIDTH'(0) - a_i) : a_i;
    assign abs_b  = b_neg ? (WIDTH'(0) - b_i) : b_i;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign ge       = (rem_sh >= {1'b0, div_q});
    assign trial    = rem_sh[WIDTH-1:0] - div_q;
    assign iter_rem = ge ? trial : rem_sh[WIDTH-1:0];
    assign iter_quo = {quo_q[WIDTH-2:0], ge};

    // Final sign fix; a zero divisor bypasses it with the MIPS-style result
    always_comb begin
        fin_lo = neg_quo_q ? (WIDTH'(0) - iter_quo) : iter_quo;
        fin_hi = neg_rem_q ? (WIDTH'(0) - iter_rem) : iter_rem;
        if (div_q == '0) begin
            fin_lo = '1;
            fin_hi = a_raw_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state, datapath update and busy indication
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_o   = 1'b0;

        case (state_q)
            IDLE: begin
                stall_o = accept;
                if (accept) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    div_d     = abs_b;
                    a_raw_d   = a_i;
                    neg_quo_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d = signed_i & a_i[WIDTH-1];
                    state_d   = BUSY;
`ifdef DIV_EARLY_OUT_EN
                    if ((b_i != '0) && (abs_a < abs_b)) begin
                        state_d = DONE;
                        lo_d    = '0;
                        hi_d    = a_i;
                    end
`endif
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                rem_d   = iter_rem;
                quo_d   = iter_quo;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Exception flush abandons the operation without touching HI/LO
        if (flush_i) begin
            state_d = IDLE;
            stall_o = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        if (rst) begin
            stall_o = 1'b0;
        end
    end

    assign valid_o = (state_q == DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: directed + randomized checks of div_radix2 against an
// arithmetic reference (MIPS DIV/DIVU semantics) and latency expectations.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_assert = 0;
    int n_fail   = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic int exp_stall_cycles(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        int n;
        n = 33;
`ifdef DIV_EARLY_OUT_EN
        if (b != 32'd0 && mag(a, sgn) < mag(b, sgn)) n = 1;
`endif
        return n;
    endfunction

    // One complete operation: start, count stall cycles, check result while
    // held for `hold` extra cycles by stall_i, then confirm return to idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int hold, input string tag);
        logic [63:0] exp;
        int          n;
        int          n_exp;
        exp   = ref_div(a, b, sgn);
        n_exp = exp_stall_cycles(a, b, sgn);
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
        stall_i  = (hold > 0);
        n = 0;
        @(negedge clk);
        while (stall_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(n_exp));
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_lo"}, lo_o, exp[31:0]);
        check({tag, "_hi"}, hi_o, exp[63:32]);
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (k == hold) stall_i = 1'b0;
            @(negedge clk);
            check({tag, "_held_valid"}, 32'(valid_o), 32'd1);
            check({tag, "_held_lo"}, lo_o, exp[31:0]);
            check({tag, "_held_hi"}, hi_o, exp[63:32]);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
    endtask

    initial begin
        logic        seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        flush_i  = 1'b0;
        stall_i  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_ovf");
        run_op(32'h0000_1234, 32'd0, 1'b0, 0, "divu_by0");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, "div_m5_by0");

        // Flush at iteration 10: no stall that cycle, no result afterwards
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b1;
        a_i      = 32'd1000;
        b_i      = 32'd7;
        repeat (11) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall_same_cycle", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || stall_o !== 1'b0) seen = 1'b1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        check("flush_hi_kept", hi_o, 32'hFFFF_FFFB);
        run_op(32'd9, 32'd3, 1'b0, 0, "divu_9_3_after_flush");

        // Result held across an external stall
        run_op(32'd50, 32'd5, 1'b0, 4, "divu_50_5_held");
        run_op(32'd3, 32'd10, 1'b0, 0, "divu_3_10");
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1, "div_m3_10");

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 15));
                3: begin
                    ra = 32'($urandom_range(0, 255));
                    rb = $urandom | 32'h0001_0000;
                end
                default: rb = $urandom;
            endcase
            run_op(ra, rb, rs, $urandom_range(0, 3), "rand");
        end

        // Async reset mid-operation clears outputs immediately
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd12345;
        b_i      = 32'd3;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(stall_o), 32'd0);
        check("rst_mid_valid", 32'(valid_o), 32'd0);
        check("rst_mid_hi", hi_o, 32'd0);
        check("rst_mid_lo", lo_o, 32'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(stall_o | valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
